// File: rtl/rst_seq_ctrl_pkg.sv
// Shared state type and delay helper for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {SYNC, SEQ, RUN, SW_HOLD} rst_seq_state_e;

    // A zero gap still costs one edge, so every domain releases on its own edge.
    function automatic logic [31:0] eff_delay(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// Reset-release synchroniser: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_,
    output logic rst_sync_
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) ff <= '0;
        else       ff <= {ff[STAGES-2:0], 1'b1};
    end

    assign rst_sync_ = ff[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_DOMAINS resets in order with programmable gaps,
// plus a software-triggered reset that holds all domains and re-runs the sequence.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         sw_rst_req,
    input  logic [CNT_W-1:0]             sw_rst_cycles,
    input  logic [NUM_DOMAINS*CNT_W-1:0] stage_delay,
    output logic [NUM_DOMAINS-1:0]       dom_rst_,
    output logic                         all_ready,
    output logic                         busy,
    output logic                         sw_rst_ack
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int LAST  = NUM_DOMAINS - 1;

    rst_seq_state_e                 state;
    logic [CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]               idx;
    logic                           rel;
    logic [(NUM_DOMAINS+1)*CNT_W-1:0] dly_ext;
    logic [CNT_W-1:0]               d0_eff, nxt_eff, cur_cnt;
    logic                           last, sw_go;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_      (rst_),
        .rst_sync_ (rel)
    );

    // The first sequencing edge happens while still in SYNC: it behaves as if
    // cnt had already been loaded with the domain-0 gap on the release edge.
    always_comb begin
        dly_ext = {{CNT_W{1'b0}}, stage_delay};
        d0_eff  = CNT_W'(eff_delay(32'(stage_delay[CNT_W-1:0])));
        nxt_eff = CNT_W'(eff_delay(32'(dly_ext[(int'(idx)+1)*CNT_W +: CNT_W])));
        last    = (idx == IDX_W'(LAST));
        cur_cnt = (state == SYNC) ? d0_eff : cnt;
        sw_go   = sw_rst_req && (sw_rst_cycles != '0) && (state == SEQ || state == RUN);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= SYNC;
            cnt        <= '0;
            idx        <= '0;
            dom_rst_   <= '0;
            all_ready  <= 1'b0;
            busy       <= 1'b1;
            sw_rst_ack <= 1'b0;
        end else begin
            sw_rst_ack <= 1'b0;
            // A software request beats a release on the same edge.
            if (sw_go) begin
                state      <= SW_HOLD;
                cnt        <= sw_rst_cycles;
                dom_rst_   <= '0;
                all_ready  <= 1'b0;
                busy       <= 1'b1;
                sw_rst_ack <= 1'b1;
            end else begin
                case (state)
                    SYNC, SEQ: begin
                        if (state == SEQ || rel) begin
                            if (cur_cnt == CNT_W'(1)) begin
                                dom_rst_[idx] <= 1'b1;
                                if (last) begin
                                    state     <= RUN;
                                    all_ready <= 1'b1;
                                    busy      <= 1'b0;
                                end else begin
                                    state <= SEQ;
                                    idx   <= idx + IDX_W'(1);
                                    cnt   <= nxt_eff;
                                end
                            end else begin
                                state <= SEQ;
                                cnt   <= cur_cnt - CNT_W'(1);
                            end
                        end
                    end
                    SW_HOLD: begin
                        if (cnt == CNT_W'(1)) begin
                            state <= SEQ;
                            idx   <= '0;
                            cnt   <= d0_eff;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    RUN:     ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: edge-time model compared every cycle plus literal checkpoints.
module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_;
    logic           sw_rst_req;
    logic [W-1:0]   sw_rst_cycles;
    logic [N*W-1:0] stage_delay;
    logic [N-1:0]   dom_rst_;
    logic           all_ready, busy, sw_rst_ack;

    int vectors = 0;
    int miscompares = 0;

    rst_seq_ctrl #(.NUM_DOMAINS(N), .CNT_W(W), .SYNC_STAGES(S)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .sw_rst_req    (sw_rst_req),
        .sw_rst_cycles (sw_rst_cycles),
        .stage_delay   (stage_delay),
        .dom_rst_      (dom_rst_),
        .all_ready     (all_ready),
        .busy          (busy),
        .sw_rst_ack    (sw_rst_ack)
    );

    always #5 clk = ~clk;

    // Model: tracks absolute edge numbers at which the next event is due.
    localparam int P_WAIT = 0, P_SEQ = 1, P_RUN = 2, P_HOLD = 3;
    int           ph = P_WAIT;
    int           n_edge = 0;
    int           since_rel = 0;
    int           k = 0;
    int           t_next = 0;
    logic [N-1:0] m_dom = '0;
    logic         m_ready = 1'b0, m_busy = 1'b1, m_ack = 1'b0;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int dly(input int i);
        return int'(stage_delay[i*W +: W]);
    endfunction

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ph = P_WAIT; since_rel = 0; m_dom = '0;
            m_ready = 1'b0; m_busy = 1'b1; m_ack = 1'b0;
        end else begin
            n_edge = n_edge + 1;
            m_ack = 1'b0;
            if ((ph == P_SEQ || ph == P_RUN) && sw_rst_req && sw_rst_cycles != 0) begin
                m_dom = '0; m_ready = 1'b0; m_busy = 1'b1; m_ack = 1'b1;
                ph = P_HOLD; t_next = n_edge + int'(sw_rst_cycles);
            end else if (ph == P_WAIT) begin
                since_rel = since_rel + 1;
                if (since_rel == S) begin
                    ph = P_SEQ; k = 0; t_next = n_edge + eff(dly(0));
                end
            end else if (ph == P_HOLD) begin
                if (n_edge == t_next) begin
                    ph = P_SEQ; k = 0; t_next = n_edge + eff(dly(0));
                end
            end else if (ph == P_SEQ) begin
                if (n_edge == t_next) begin
                    m_dom[k] = 1'b1;
                    if (k == N-1) begin
                        ph = P_RUN; m_ready = 1'b1; m_busy = 1'b0;
                    end else begin
                        k = k + 1; t_next = n_edge + eff(dly(k));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors = vectors + 1;
        if ({dom_rst_, all_ready, busy, sw_rst_ack} !== {m_dom, m_ready, m_busy, m_ack}) begin
            miscompares = miscompares + 1;
            $display("FAIL model t=%0t: dom/ready/busy/ack got %b %b %b %b want %b %b %b %b",
                     $time, dom_rst_, all_ready, busy, sw_rst_ack, m_dom, m_ready, m_busy, m_ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d);
        stage_delay = {W'(d), W'(c), W'(b), W'(a)};
    endtask

    task automatic sw_pulse(input int cyc);
        sw_rst_cycles = W'(cyc);
        sw_rst_req    = 1'b1;
        @(negedge clk);
        sw_rst_req    = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int i;
        for (i = 0; i < limit && !all_ready; i++) @(negedge clk);
        chk(name, 32'(all_ready), 32'd1);
    endtask

    initial begin
        rst_ = 1'b1; sw_rst_req = 1'b0; sw_rst_cycles = '0;
        set_dly(3, 1, 0, 5);
        #1 rst_ = 1'b0;
        edges(2);
        chk("rst_dom", 32'(dom_rst_), 32'h0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(all_ready), 32'd0);
        chk("rst_ack", 32'(sw_rst_ack), 32'd0);

        // Power-on sequence: E0 = edge 1; releases at edges 4,5,6,11.
        rst_ = 1'b1;
        edges(4); chk("por_e3", 32'(dom_rst_), 32'h0);
        edges(1); chk("por_e4", 32'(dom_rst_), 32'h1);
        edges(1); chk("por_e5", 32'(dom_rst_), 32'h3);
        edges(1); chk("por_e6", 32'(dom_rst_), 32'h7);
        edges(4); chk("por_e10", 32'(dom_rst_), 32'h7);
        chk("por_e10_busy", 32'(busy), 32'd1);
        edges(1); chk("por_e11", 32'(dom_rst_), 32'hf);
        chk("por_ready", 32'(all_ready), 32'd1);
        chk("por_busy", 32'(busy), 32'd0);

        // Software reset, 6 hold cycles, gaps of 2.
        set_dly(2, 2, 2, 2);
        sw_pulse(6);
        chk("sw_ack", 32'(sw_rst_ack), 32'd1);
        chk("sw_dom", 32'(dom_rst_), 32'h0);
        chk("sw_busy", 32'(busy), 32'd1);
        edges(1); chk("sw_ack_drop", 32'(sw_rst_ack), 32'd0);
        edges(6); chk("sw_a7", 32'(dom_rst_), 32'h0);
        edges(1); chk("sw_a8", 32'(dom_rst_), 32'h1);
        edges(5); chk("sw_a13", 32'(dom_rst_), 32'h7);
        edges(1); chk("sw_a14", 32'(dom_rst_), 32'hf);
        chk("sw_ready", 32'(all_ready), 32'd1);

        // Zero-cycle request is ignored.
        sw_pulse(0);
        chk("sw0_ack", 32'(sw_rst_ack), 32'd0);
        chk("sw0_dom", 32'(dom_rst_), 32'hf);
        edges(1); chk("sw0_busy", 32'(busy), 32'd0);

        // Asynchronous reset after domain 1 released, then full restart.
        sw_pulse(1);
        edges(5); chk("ar_pre", 32'(dom_rst_), 32'h3);
        #2 rst_ = 1'b0;
        #1;
        chk("ar_dom", 32'(dom_rst_), 32'h0);
        chk("ar_ready", 32'(all_ready), 32'd0);
        chk("ar_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_ = 1'b1;
        edges(3); chk("ar_e2", 32'(dom_rst_), 32'h0);
        edges(1); chk("ar_e3", 32'(dom_rst_), 32'h1);
        wait_ready("ar_ready_wait", 40);
        chk("ar_done", 32'(dom_rst_), 32'hf);

        // Request on the edge domain 2 would release.
        sw_pulse(1);
        edges(6); chk("col_pre", 32'(dom_rst_), 32'h3);
        sw_pulse(3);
        chk("col_dom", 32'(dom_rst_), 32'h0);
        chk("col_ack", 32'(sw_rst_ack), 32'd1);
        edges(4); chk("col_b4", 32'(dom_rst_), 32'h0);
        edges(1); chk("col_b5", 32'(dom_rst_), 32'h1);
        wait_ready("col_ready_wait", 40);

        // Gap for domain 3 changed while domain 2 is counting.
        set_dly(1, 1, 4, 5);
        sw_pulse(1);
        edges(4);
        set_dly(1, 1, 4, 1);
        edges(3); chk("chg_a7", 32'(dom_rst_), 32'h7);
        edges(1); chk("chg_a8", 32'(dom_rst_), 32'hf);
        chk("chg_ready", 32'(all_ready), 32'd1);

        edges(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
